// File: rtl/dnn_stream_dma.sv
// Host-side stream DMA: TX streams a scratch-memory block out on src, RX writes the dst stream
// back to scratch memory. The two channels are fully independent.
module dnn_stream_dma #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32,
  parameter int unsigned LW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tx_start,
  input  logic [AW-1:0] tx_base,
  input  logic [LW-1:0] tx_len,
  output logic          tx_busy,
  output logic          tx_done,
  output logic          mr_en,
  output logic [AW-1:0] mr_addr,
  input  logic [DW-1:0] mr_data,
  output logic          src_valid,
  output logic [DW-1:0] src_data,
  output logic          src_last,
  input  logic          src_ready,
  input  logic          rx_start,
  input  logic [AW-1:0] rx_base,
  input  logic [LW-1:0] rx_len,
  output logic          rx_busy,
  output logic          rx_done,
  output logic          rx_err,
  output logic          mw_en,
  output logic [AW-1:0] mw_addr,
  output logic [DW-1:0] mw_data,
  input  logic          dst_valid,
  input  logic [DW-1:0] dst_data,
  input  logic          dst_last,
  output logic          dst_ready
);

  typedef enum logic {TxIdle, TxRun} tx_state_e;
  typedef enum logic {RxIdle, RxRun} rx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [AW-1:0]   tx_base_q, tx_base_d;
  logic [LW-1:0]   tx_len_q, tx_len_d;
  logic [LW-1:0]   tx_issued_q, tx_issued_d;
  logic [LW-1:0]   tx_sent_q, tx_sent_d;
  logic            tx_done_q, tx_done_d;
  logic            rd_pend_q;
  logic [DW-1:0]   fifo_mem_q [2];
  logic            fifo_wptr_q, fifo_rptr_q;
  logic [1:0]      fifo_cnt_q;
  logic            tx_pop;
  logic [1:0]      tx_occ;

  rx_state_e       rx_state_q, rx_state_d;
  logic [AW-1:0]   rx_base_q, rx_base_d;
  logic [LW-1:0]   rx_len_q, rx_len_d;
  logic [LW-1:0]   rx_cnt_q, rx_cnt_d;
  logic            rx_err_q, rx_err_d;
  logic            rx_done_q, rx_done_d;
  logic            rx_hs;
  logic            rx_final_idx;

  // ---------------- TX channel ----------------
  assign src_valid = (fifo_cnt_q != 2'd0);
  assign src_data  = fifo_mem_q[fifo_rptr_q];
  assign src_last  = src_valid && (tx_sent_q == tx_len_q - LW'(1));
  assign tx_pop    = src_valid & src_ready;
  // In-flight plus buffered words after this cycle's pop; keeps the FIFO from overflowing
  // while still allowing one beat per cycle under full throughput.
  assign tx_occ    = fifo_cnt_q + {1'b0, rd_pend_q} - {1'b0, tx_pop};
  assign mr_en     = (tx_state_q == TxRun) && (tx_issued_q < tx_len_q) && (tx_occ < 2'd2);
  assign mr_addr   = mr_en ? (tx_base_q + AW'(tx_issued_q)) : '0;
  assign tx_busy   = (tx_state_q == TxRun);
  assign tx_done   = tx_done_q;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_base_d   = tx_base_q;
    tx_len_d    = tx_len_q;
    tx_issued_d = tx_issued_q;
    tx_sent_d   = tx_sent_q;
    tx_done_d   = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        if (tx_start) begin
          if (tx_len != '0) begin
            tx_base_d   = tx_base;
            tx_len_d    = tx_len;
            tx_issued_d = '0;
            tx_sent_d   = '0;
            tx_state_d  = TxRun;
          end else begin
            tx_done_d = 1'b1;
          end
        end
      end
      TxRun: begin
        if (mr_en) tx_issued_d = tx_issued_q + LW'(1);
        if (tx_pop) begin
          tx_sent_d = tx_sent_q + LW'(1);
          if (src_last) begin
            tx_state_d = TxIdle;
            tx_done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q    <= TxIdle;
      tx_base_q     <= '0;
      tx_len_q      <= '0;
      tx_issued_q   <= '0;
      tx_sent_q     <= '0;
      tx_done_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      fifo_wptr_q   <= 1'b0;
      fifo_rptr_q   <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_base_q   <= tx_base_d;
      tx_len_q    <= tx_len_d;
      tx_issued_q <= tx_issued_d;
      tx_sent_q   <= tx_sent_d;
      tx_done_q   <= tx_done_d;
      // Read data lands one cycle after mr_en; a read pending across reset is dropped.
      rd_pend_q   <= mr_en;
      if (rd_pend_q) begin
        fifo_mem_q[fifo_wptr_q] <= mr_data;
        fifo_wptr_q             <= ~fifo_wptr_q;
      end
      if (tx_pop) fifo_rptr_q <= ~fifo_rptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, rd_pend_q} - {1'b0, tx_pop};
    end
  end

  // ---------------- RX channel ----------------
  assign dst_ready    = (rx_state_q == RxRun);
  assign rx_hs        = dst_valid & dst_ready;
  assign rx_final_idx = (rx_cnt_q == rx_len_q - LW'(1));
  assign mw_en        = rx_hs;
  assign mw_addr      = rx_hs ? (rx_base_q + AW'(rx_cnt_q)) : '0;
  assign mw_data      = rx_hs ? dst_data : '0;
  assign rx_busy      = (rx_state_q == RxRun);
  assign rx_done      = rx_done_q;
  assign rx_err       = rx_err_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_base_d  = rx_base_q;
    rx_len_d   = rx_len_q;
    rx_cnt_d   = rx_cnt_q;
    rx_err_d   = rx_err_q;
    rx_done_d  = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_start) begin
          rx_base_d = rx_base;
          rx_len_d  = rx_len;
          rx_cnt_d  = '0;
          rx_err_d  = 1'b0;
          if (rx_len != '0) rx_state_d = RxRun;
          else              rx_done_d  = 1'b1;
        end
      end
      RxRun: begin
        if (rx_hs) begin
          rx_cnt_d = rx_cnt_q + LW'(1);
          // Either an early last or a missing last on the final beat is a framing error.
          if (dst_last != rx_final_idx) rx_err_d = 1'b1;
          if (dst_last || rx_final_idx) begin
            rx_state_d = RxIdle;
            rx_done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RxIdle;
      rx_base_q  <= '0;
      rx_len_q   <= '0;
      rx_cnt_q   <= '0;
      rx_err_q   <= 1'b0;
      rx_done_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_base_q  <= rx_base_d;
      rx_len_q   <= rx_len_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_err_q   <= rx_err_d;
      rx_done_q  <= rx_done_d;
    end
  end

endmodule

// File: tb/tb_dnn_stream_dma.sv
// Directed bench for dnn_stream_dma: behavioural scratch memory, stream logging monitor and
// immediate-assertion checks in one linear stimulus sequence.
module tb_dnn_stream_dma;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LW = 12;

  logic          clk, rst;
  logic          tx_start, tx_busy, tx_done, mr_en, src_valid, src_last, src_ready;
  logic [AW-1:0] tx_base, mr_addr, rx_base, mw_addr;
  logic [LW-1:0] tx_len, rx_len;
  logic [DW-1:0] mr_data, src_data, mw_data, dst_data;
  logic          rx_start, rx_busy, rx_done, rx_err, mw_en, dst_valid, dst_last, dst_ready;

  dnn_stream_dma #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .tx_start(tx_start), .tx_base(tx_base), .tx_len(tx_len), .tx_busy(tx_busy),
    .tx_done(tx_done), .mr_en(mr_en), .mr_addr(mr_addr), .mr_data(mr_data),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
    .rx_start(rx_start), .rx_base(rx_base), .rx_len(rx_len), .rx_busy(rx_busy),
    .rx_done(rx_done), .rx_err(rx_err), .mw_en(mw_en), .mw_addr(mw_addr), .mw_data(mw_data),
    .dst_valid(dst_valid), .dst_data(dst_data), .dst_last(dst_last), .dst_ready(dst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:4095];
  always @(posedge clk) begin
    if (mr_en) mr_data <= mem[mr_addr];
    if (mw_en) mem[mw_addr] <= mw_data;
  end

  logic [DW-1:0] beats[$];
  logic          lasts[$];
  logic [AW-1:0] raddr[$];
  logic [AW-1:0] waddr[$];
  logic [DW-1:0] wdata[$];
  int txd, rxd, stab_err, occ, max_occ;
  logic pv, pr, pl;
  logic [DW-1:0] pd;

  // Passive monitor: logs handshakes, reads and writes; tracks stall stability and occupancy.
  always @(posedge clk) begin
    if (rst) begin
      occ = 0;
      pv  = 1'b0;
    end else begin
      if (pv && !pr && (!src_valid || src_data !== pd || src_last !== pl)) stab_err++;
      pv = src_valid; pr = src_ready; pd = src_data; pl = src_last;
      if (mr_en) begin raddr.push_back(mr_addr); occ++; end
      if (src_valid && src_ready) begin
        beats.push_back(src_data);
        lasts.push_back(src_last);
        occ--;
      end
      if (occ > max_occ) max_occ = occ;
      if (mw_en) begin waddr.push_back(mw_addr); wdata.push_back(mw_data); end
      if (tx_done) txd++;
      if (rx_done) rxd++;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    beats.delete(); lasts.delete(); raddr.delete(); waddr.delete(); wdata.delete();
    txd = 0; rxd = 0; stab_err = 0; max_occ = 0;
  endtask

  task automatic wait_tx_done();
    int n = 0;
    while (!tx_done && n < 40) begin tick(); n++; end
    chk("tx_done_seen", tx_done, 1'b1);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int n = 0;
    dst_valid = 1'b1; dst_data = d; dst_last = l;
    #1;
    while (!dst_ready && n < 20) begin tick(); n++; end
    chk("rx_ready", dst_ready, 1'b1);
    chk("rx_mw_en", mw_en, 1'b1);
    tick();
    dst_valid = 1'b0; dst_last = 1'b0; dst_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [5:0] pat;
    int ws;
    rst = 1'b1;
    tx_start = 0; tx_base = '0; tx_len = '0; src_ready = 0;
    rx_start = 0; rx_base = '0; rx_len = '0; dst_valid = 0; dst_data = '0; dst_last = 0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem[12'h010 + i] = 32'hA000_00A0 + i;
    for (int i = 0; i < 3; i++) mem[12'h020 + i] = 32'hC0C0_0000 + i;
    for (int i = 0; i < 2; i++) mem[12'h030 + i] = 32'h3030_0000 + i;
    for (int i = 0; i < 8; i++) mem[12'h050 + i] = 32'h5050_0000 + i;
    clear_logs();
    tick(); tick();
    chk("rst_tx_busy", tx_busy, 0);   chk("rst_tx_done", tx_done, 0);
    chk("rst_mr_en", mr_en, 0);       chk("rst_src_valid", src_valid, 0);
    chk("rst_src_data", src_data, 0); chk("rst_src_last", src_last, 0);
    chk("rst_rx_busy", rx_busy, 0);   chk("rst_rx_done", rx_done, 0);
    chk("rst_rx_err", rx_err, 0);     chk("rst_mw_en", mw_en, 0);
    chk("rst_dst_ready", dst_ready, 0);
    rst = 1'b0;
    tick();

    // Streaming TX
    clear_logs();
    src_ready = 1; tx_base = 12'h010; tx_len = 4; tx_start = 1;
    tick();
    tx_start = 0;
    #1;
    chk("t1_busy", tx_busy, 1); chk("t1_mr_en", mr_en, 1);
    chk("t1_mr_addr0", mr_addr, 12'h010); chk("t1_valid_e0", src_valid, 0);
    tick();
    chk("t1_valid_e1", src_valid, 0);
    tick();
    chk("t1_valid_e2", src_valid, 1); chk("t1_data_e2", src_data, 32'hA000_00A0);
    chk("t1_last_e2", src_last, 0);
    wait_tx_done();
    chk("t1_busy_done", tx_busy, 0);
    chk("t1_nbeats", beats.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_beat", beats[i], 32'hA000_00A0 + i);
      chk("t1_last", lasts[i], (i == 3));
      chk("t1_raddr", raddr[i], 12'h010 + i);
    end
    chk("t1_nreads", raddr.size(), 4);
    tick();
    chk("t1_done_pulse", tx_done, 0); chk("t1_ndone", txd, 1);

    // TX backpressure
    clear_logs();
    pat = 6'b101001;
    src_ready = pat[0]; tx_base = 12'h020; tx_len = 3; tx_start = 1;
    tick();
    tx_start = 0;
    for (int i = 1; i < 6; i++) begin src_ready = pat[i]; tick(); end
    src_ready = 1;
    wait_tx_done();
    chk("t2_nbeats", beats.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_beat", beats[i], 32'hC0C0_0000 + i);
      chk("t2_last", lasts[i], (i == 2));
    end
    chk("t2_stable", stab_err, 0);
    chk("t2_occ_le2", (max_occ <= 2), 1);
    chk("t2_nreads", raddr.size(), 3);
    tick();

    // Normal RX with address wrap
    clear_logs();
    rx_base = 12'hFFE; rx_len = 3; rx_start = 1;
    tick();
    rx_start = 0;
    #1;
    chk("t3_busy", rx_busy, 1); chk("t3_ready", dst_ready, 1); chk("t3_err0", rx_err, 0);
    send_beat(32'hB000_0000, 0);
    send_beat(32'hB000_0001, 0);
    send_beat(32'hB000_0002, 1);
    chk("t3_done", rx_done, 1); chk("t3_busy_done", rx_busy, 0);
    chk("t3_ready_done", dst_ready, 0); chk("t3_err", rx_err, 0);
    chk("t3_nwr", waddr.size(), 3);
    chk("t3_wa0", waddr[0], 12'hFFE); chk("t3_wa1", waddr[1], 12'hFFF);
    chk("t3_wa2", waddr[2], 12'h000); chk("t3_wd2", wdata[2], 32'hB000_0002);
    chk("t3_mem0", mem[0], 32'hB000_0002);
    tick();
    chk("t3_done_pulse", rx_done, 0); chk("t3_ndone", rxd, 1);

    // RX early last
    clear_logs();
    rx_base = 12'h200; rx_len = 4; rx_start = 1;
    tick();
    rx_start = 0;
    send_beat(32'hD000_0000, 0);
    send_beat(32'hD000_0001, 1);
    chk("t4a_done", rx_done, 1); chk("t4a_err", rx_err, 1);
    chk("t4a_busy", rx_busy, 0); chk("t4a_nwr", waddr.size(), 2);
    tick();
    chk("t4a_err_sticky", rx_err, 1);
    tick();
    chk("t4a_nwr_after", waddr.size(), 2);

    // RX missing last
    clear_logs();
    rx_base = 12'h210; rx_len = 2; rx_start = 1;
    tick();
    rx_start = 0;
    #1;
    chk("t4b_err_clr", rx_err, 0);
    send_beat(32'hE000_0000, 0);
    send_beat(32'hE000_0001, 0);
    chk("t4b_err", rx_err, 1); chk("t4b_done", rx_done, 1);
    chk("t4b_nwr", waddr.size(), 2); chk("t4b_wd1", wdata[1], 32'hE000_0001);
    tick();

    // Zero-length TX
    clear_logs();
    tx_base = 12'h010; tx_len = 0; tx_start = 1;
    tick();
    tx_start = 0;
    #1;
    chk("t5a_done", tx_done, 1); chk("t5a_busy", tx_busy, 0); chk("t5a_valid", src_valid, 0);
    chk("t5a_mr_en", mr_en, 0);
    tick();
    chk("t5a_done_pulse", tx_done, 0); chk("t5a_valid2", src_valid, 0);
    chk("t5a_nreads", raddr.size(), 0);

    // Start while busy is ignored
    clear_logs();
    src_ready = 1; tx_base = 12'h030; tx_len = 2; tx_start = 1;
    tick();
    tx_base = 12'h040; tx_len = 5;
    tick();
    tx_start = 0;
    wait_tx_done();
    chk("t5b_nbeats", beats.size(), 2);
    chk("t5b_beat1", beats[1], 32'h3030_0001); chk("t5b_last1", lasts[1], 1);
    chk("t5b_nreads", raddr.size(), 2); chk("t5b_raddr1", raddr[1], 12'h031);
    tick(); tick();
    chk("t5b_idle", tx_busy, 0); chk("t5b_nbeats_after", beats.size(), 2);

    // Mid-transfer reset with both channels running
    clear_logs();
    src_ready = 1; tx_base = 12'h050; tx_len = 8; rx_base = 12'h100; rx_len = 8;
    tx_start = 1; rx_start = 1; dst_valid = 1; dst_data = 32'hF000_0000; dst_last = 0;
    tick();
    tx_start = 0; rx_start = 0;
    for (int n = 0; n < 30 && beats.size() < 3; n++) begin
      dst_data = dst_data + 1;
      tick();
    end
    chk("t6_reached_b3", beats.size(), 3);
    rst = 1; dst_valid = 0; dst_data = '0;
    tick();
    chk("t6_tx_busy", tx_busy, 0); chk("t6_tx_done", tx_done, 0);
    chk("t6_mr_en", mr_en, 0);     chk("t6_src_valid", src_valid, 0);
    chk("t6_src_data", src_data, 0);
    chk("t6_rx_busy", rx_busy, 0); chk("t6_rx_done", rx_done, 0);
    chk("t6_rx_err", rx_err, 0);   chk("t6_mw_en", mw_en, 0);
    chk("t6_dst_ready", dst_ready, 0);
    rst = 0;
    ws = waddr.size();
    tick(); tick(); tick();
    chk("t6_no_txdone", txd, 0); chk("t6_no_rxdone", rxd, 0);
    chk("t6_valid_after", src_valid, 0); chk("t6_no_writes", waddr.size(), ws);
    chk("t6_nbeats_after", beats.size(), 3);

    // Fresh transfers after reset
    clear_logs();
    tx_base = 12'h010; tx_len = 2; tx_start = 1;
    tick();
    tx_start = 0;
    wait_tx_done();
    chk("t6_fresh_nbeats", beats.size(), 2);
    chk("t6_fresh_b0", beats[0], 32'h A000_00A0);
    chk("t6_fresh_b1", beats[1], 32'hA000_00A1);
    chk("t6_fresh_last", lasts[1], 1);
    rx_base = 12'h300; rx_len = 1; rx_start = 1;
    tick();
    rx_start = 0;
    send_beat(32'h6000_0000, 1);
    chk("t6_fresh_rxdone", rx_done, 1); chk("t6_fresh_rxerr", rx_err, 0);
    chk("t6_fresh_mem", mem[12'h300], 32'h6000_0000);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dnn_stream_dma.md
Name: dnn_stream_dma

Overview:
Host-side stream engine for the DNN accelerator's src/dst AXI-stream-style ports.
- TX channel reads a word block from local scratch memory and transmits it as the src stream (valid/data/last, honouring ready).
- RX channel accepts the dst stream and writes it back to the same scratch memory.
- Lets test benches and the SoC wrapper drive weight, bias and sample loads and collect results without a CPU in the loop.

Parameters:
AW, 12, scratch memory word-address width
DW, 32, data word width
LW, 12, transfer length width (words)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
tx_start  in  1  start TX; sampled only while tx_busy=0
tx_base  in  AW  TX start word address
tx_len  in  LW  TX word count; 0 = empty transfer
tx_busy  out  1  TX in progress
tx_done  out  1  one-cycle pulse at TX completion
mr_en  out  1  memory read enable
mr_addr  out  AW  memory read address
mr_data  in  DW  read data, valid exactly 1 cycle after mr_en
src_valid  out  1  stream beat valid
src_data  out  DW  stream beat data
src_last  out  1  final beat marker
src_ready  in  1  sink accepts beat
rx_start  in  1  start RX; sampled only while rx_busy=0
rx_base  in  AW  RX start word address
rx_len  in  LW  expected RX word count; 0 = empty transfer
rx_busy  out  1  RX in progress
rx_done  out  1  one-cycle pulse at RX completion
rx_err  out  1  sticky length/last mismatch flag
mw_en  out  1  memory write enable
mw_addr  out  AW  memory write address
mw_data  out  DW  memory write data
dst_valid  in  1  incoming beat valid
dst_data  in  DW  incoming beat data
dst_last  in  1  incoming final beat marker
dst_ready  out  1  RX accepts beat

Behaviour:
Reset:
- All outputs 0; both FSMs go to IDLE; skid FIFO is emptied; counters are cleared.
- Reset mid-transfer abandons the transfer. No done pulse, no further mr_en/mw_en.
- A read whose data returns after reset is discarded.

TX FSM (IDLE, RUN):
- IDLE: when tx_start=1 and tx_len!=0, latch base and len, clear the issue count and the sent count, go to RUN, tx_busy=1 next cycle.
- IDLE: when tx_start=1 and tx_len=0, tx_done pulses next cycle; no beats, no reads.
- RUN read issue: read word k at mr_addr=base+k (mod 2^AW) when issued<len and (outstanding reads + FIFO occupancy)<2.
- RUN FIFO: mr_data is pushed into a 2-entry FIFO one cycle after mr_en.
- FIFO head drives src_valid and src_data; src_last=1 only on beat index len-1.
- Once src_valid=1, src_data and src_last stay stable until src_ready=1 (no retraction).
- With src_ready held at 1, throughput is 1 beat/cycle. The first beat appears 2 cycles after the start-sampling edge (issue cycle, then data cycle).
- On the handshake of beat len-1: tx_done=1 for one cycle in the next cycle, tx_busy falls in that same cycle, and the FSM returns to IDLE.
- tx_start while busy is ignored.

RX FSM (IDLE, RUN):
- IDLE: when rx_start=1, latch base and len, clear rx_err and the beat count, go to RUN. rx_len=0 gives an rx_done pulse next cycle, with dst_ready kept at 0.
- RUN: dst_ready=1. On each handshake (dst_valid and dst_ready), in the same cycle: mw_en=1, mw_addr=base+count (mod 2^AW), mw_data=dst_data. Write is combinational from the handshake; count increments.
- Normal end: the handshake of beat len-1 carries dst_last=1. rx_done pulses next cycle and the FSM returns to IDLE.
- Early last (dst_last=1 on beat index <len-1): the beat is written, rx_err=1, completion follows as in the normal end.
- Missing last (beat len-1 without dst_last): rx_err=1, completion follows as in the normal end.
- dst_ready=0 in IDLE and in the done cycle.
- rx_err stays set until the next accepted rx_start.

Channel independence:
- TX and RX are fully independent and may run concurrently.
- Memory read and write ports are separate; same-cycle read/write of the same address returns old data (memory's responsibility, noted for the bench).

Width rules:
- Counters are LW bits; the maximum length is 2^LW-1.
- Addresses wrap modulo 2^AW with no error.

Test Plan:
1. Streaming TX: tx_base=0x010, tx_len=4, memory[0x010..0x013]=A0..A3, src_ready=1 -> beats A0..A3 on 4 consecutive cycles, src_last only on A3, one tx_done pulse, mr_addr 0x010..0x013.
2. TX backpressure: tx_len=3, src_ready toggling 1,0,0,1,0,1 -> data stable while stalled, no lost or duplicated word, never more than 2 reads outstanding or buffered.
3. Normal RX: rx_base=0xFFE, rx_len=3, beats B0,B1,B2 with last on B2 -> writes to 0xFFE, 0xFFF, 0x000, rx_err=0, rx_done pulse.
4. RX framing errors:
   - rx_len=4, dst_last on beat 2 -> 2 writes, rx_err=1, rx_done.
   - Separate run, rx_len=2, no last -> 2 writes, rx_err=1.
5. Zero length and ignore-while-busy:
   - tx_len=0 -> tx_done one cycle later, src_valid stays 0.
   - Second tx_start during a busy transfer -> ignored, beat count unchanged.
6. Mid-transfer reset with concurrent channels: TX (len=8) and RX (len=8) running together, rst=1 at beat 3 -> next cycle all outputs 0, no done pulses. A fresh transfer afterwards completes correctly.
